// File: rtl/cflog_drain.sv
// Drains the CFLog memory towards the UART log-transmit controller: a count header,
// then every logged entry in address order, then a one-cycle clear pulse to the log writer.
module cflog_drain #(
    parameter int LOG_ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  puc_rst,
    input  logic                  acfa_nmi,
    input  logic [LOG_ADDR_W:0]   log_ptr,
    output logic                  mem_rd_en,
    output logic [LOG_ADDR_W-1:0] mem_addr,
    input  logic [15:0]           mem_rdata,
    output logic [15:0]           read_val,
    output logic                  word_valid,
    input  logic                  word_ack,
    output logic                  busy,
    output logic                  log_clr,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR     = 3'd1,
        RD_REQ  = 3'd2,
        RD_WAIT = 3'd3,
        PRESENT = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [LOG_ADDR_W:0] CAP = {1'b1, {LOG_ADDR_W{1'b0}}};

    state_t                state;
    logic [LOG_ADDR_W:0]   cnt;
    logic [LOG_ADDR_W:0]   idx;
    logic [LOG_ADDR_W:0]   idx_next;
    logic [LOG_ADDR_W:0]   ptr_clamped;

    assign ptr_clamped = (log_ptr > CAP) ? CAP : log_ptr;
    assign idx_next    = idx + (LOG_ADDR_W + 1)'(1);
    assign dbg_state   = state;

    // Handshake: a word moves on the clk edge where word_valid and word_ack are both 1;
    // read_val/word_valid hold until then, word_ack with word_valid low is ignored, and
    // word_valid drops the cycle after acceptance.
    always_ff @(posedge clk or posedge puc_rst) begin
        if (puc_rst) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            read_val   <= '0;
            word_valid <= 1'b0;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            busy       <= 1'b0;
            log_clr    <= 1'b0;
        end else begin
            log_clr <= 1'b0;
            case (state)
                IDLE: begin
                    if (acfa_nmi) begin
                        cnt   <= ptr_clamped;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= HDR;
                    end
                end
                HDR: begin
                    if (!word_valid) begin
                        read_val   <= 16'(cnt);
                        word_valid <= 1'b1;
                    end else if (word_ack) begin
                        word_valid <= 1'b0;
                        state      <= (cnt == '0) ? DONE : RD_REQ;
                    end
                end
                RD_REQ: begin
                    mem_rd_en <= 1'b1;
                    mem_addr  <= idx[LOG_ADDR_W-1:0];
                    state     <= RD_WAIT;
                end
                RD_WAIT: begin
                    // First cycle retires the strobe; read data is captured on the second.
                    if (mem_rd_en) begin
                        mem_rd_en <= 1'b0;
                    end else begin
                        read_val   <= mem_rdata;
                        word_valid <= 1'b1;
                        state      <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (word_ack) begin
                        word_valid <= 1'b0;
                        idx        <= idx_next;
                        state      <= (idx_next == cnt) ? DONE : RD_REQ;
                    end
                end
                DONE: begin
                    log_clr <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cflog_drain.sv
// Directed bench for cflog_drain with a 4-entry CFLog (LOG_ADDR_W=2) so the clamp case is short.
module tb_cflog_drain;

    localparam int W = 2;

    logic           clk = 1'b0;
    logic           puc_rst;
    logic           acfa_nmi;
    logic [W:0]     log_ptr;
    logic           mem_rd_en;
    logic [W-1:0]   mem_addr;
    logic [15:0]    mem_rdata;
    logic [15:0]    read_val;
    logic           word_valid;
    logic           word_ack;
    logic           busy;
    logic           log_clr;
    logic [2:0]     dbg_state;

    logic [15:0]    mem [4];
    int             checks = 0;
    int             errors = 0;
    int             clr_cnt = 0;
    logic [15:0]    exp_q[$];
    logic [15:0]    got_q[$];
    logic [W-1:0]   rd_addr_q[$];
    int             got_base;
    int             rd_base;
    int             clr_base;

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $fatal(1, "FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    end

    cflog_drain #(.LOG_ADDR_W(W)) dut (
        .clk        (clk),
        .puc_rst    (puc_rst),
        .acfa_nmi   (acfa_nmi),
        .log_ptr    (log_ptr),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .read_val   (read_val),
        .word_valid (word_valid),
        .word_ack   (word_ack),
        .busy       (busy),
        .log_clr    (log_clr),
        .dbg_state  (dbg_state)
    );

    // CFLog model: data valid only in the cycle after the strobe
    always @(posedge clk) mem_rdata <= mem_rd_en ? mem[mem_addr] : 16'hDEAD;

    // monitor
    always @(posedge clk) begin
        if (mem_rd_en) rd_addr_q.push_back(mem_addr);
        if (log_clr) clr_cnt++;
        if (word_valid && word_ack) got_q.push_back(read_val);
    end

    // driver / checking tasks
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic trigger();
        acfa_nmi = 1'b1;
        tick(1);
        acfa_nmi = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int t = 0;
        while (!word_valid && t < 40) begin
            tick(1);
            t++;
        end
        chk(tag, {31'd0, word_valid}, 32'd1);
    endtask

    task automatic ack_word(input int delay);
        wait_valid("valid_timeout");
        if (word_valid) begin
            tick(delay);
            word_ack = 1'b1;
            tick(1);
            word_ack = 1'b0;
        end
    endtask

    task automatic mark();
        got_base = got_q.size();
        rd_base  = rd_addr_q.size();
        clr_base = clr_cnt;
    endtask

    task automatic sb_check(input string tag);
        logic [15:0] g;
        chk({tag, "_count"}, got_q.size() - got_base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (got_base + i < got_q.size()) ? got_q[got_base + i] : 16'hxxxx;
            chk($sformatf("%s_word%0d", tag, i), {16'd0, g}, {16'd0, exp_q[i]});
        end
        exp_q.delete();
    endtask

    task automatic rd_check(input string tag, input int n);
        logic [W-1:0] a;
        chk({tag, "_rd_count"}, rd_addr_q.size() - rd_base, n);
        for (int i = 0; i < n; i++) begin
            a = (rd_base + i < rd_addr_q.size()) ? rd_addr_q[rd_base + i] : 'x;
            chk($sformatf("%s_rd_addr%0d", tag, i), {30'd0, a}, i);
        end
    endtask

    initial begin
        puc_rst  = 1'b1;
        acfa_nmi = 1'b1;
        word_ack = 1'b0;
        log_ptr  = 3'd3;
        mem[0] = 16'hABCD; mem[1] = 16'h1234; mem[2] = 16'h00FF; mem[3] = 16'h5A5A;

        // reset, with the trigger held high throughout
        tick(2);
        chk("rst_outputs", {read_val, word_valid, mem_rd_en, 6'(mem_addr), busy, log_clr},
            32'd0);
        chk("rst_state", dbg_state, 32'd0);
        puc_rst  = 1'b0;
        acfa_nmi = 1'b0;
        tick(3);
        chk("post_rst_idle", {dbg_state, busy, word_valid, mem_rd_en}, 32'd0);
        chk("post_rst_no_reads", rd_addr_q.size(), 32'd0);

        // basic drain, ack two cycles after each valid
        mark();
        exp_q = '{16'h0003, 16'hABCD, 16'h1234, 16'h00FF};
        trigger();
        for (int i = 0; i < 4; i++) ack_word(2);
        tick(3);
        sb_check("basic");
        rd_check("basic", 3);
        chk("basic_clr", clr_cnt - clr_base, 32'd1);
        chk("basic_busy", busy, 32'd0);
        chk("basic_state", dbg_state, 32'd0);

        // empty log
        mark();
        log_ptr = 3'd0;
        exp_q = '{16'h0000};
        trigger();
        ack_word(1);
        chk("empty_clr_early", log_clr, 32'd0);
        tick(1);
        chk("empty_clr_pulse", {log_clr, busy}, 32'b10);
        tick(1);
        chk("empty_clr_end", log_clr, 32'd0);
        tick(2);
        sb_check("empty");
        rd_check("empty", 0);
        chk("empty_clr_count", clr_cnt - clr_base, 32'd1);

        // clamp: log_ptr 7 with a 4-entry log
        mark();
        mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
        log_ptr = 3'd7;
        exp_q = '{16'h0004, 16'h1111, 16'h2222, 16'h3333, 16'h4444};
        trigger();
        for (int i = 0; i < 5; i++) ack_word($urandom_range(0, 3));
        tick(3);
        sb_check("clamp");
        rd_check("clamp", 4);
        chk("clamp_clr", clr_cnt - clr_base, 32'd1);
        chk("clamp_busy", busy, 32'd0);

        // backpressure on the second word, with retrigger and log_ptr change
        mark();
        mem[0] = 16'h0A0A; mem[1] = 16'h0B0B; mem[2] = 16'h0C0C; mem[3] = 16'h0D0D;
        log_ptr = 3'd4;
        exp_q = '{16'h0004, 16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D};
        trigger();
        ack_word(1);
        wait_valid("bp_valid_timeout");
        for (int i = 0; i < 20; i++) begin
            chk("bp_hold", {word_valid, read_val}, 32'h10A0A);
            chk("bp_state", dbg_state, 32'd4);
            if (i == 5) acfa_nmi = 1'b1;
            if (i == 6) acfa_nmi = 1'b0;
            if (i == 8) log_ptr = 3'd1;
            tick(1);
        end
        ack_word(0);
        for (int i = 0; i < 3; i++) ack_word($urandom_range(0, 3));
        tick(3);
        sb_check("bp");
        rd_check("bp", 4);
        chk("bp_clr", clr_cnt - clr_base, 32'd1);
        tick(5);
        chk("bp_no_restart", {busy, word_valid}, 32'd0);
        chk("bp_no_extra_reads", rd_addr_q.size() - rd_base, 32'd4);

        // reset while entry 1 is presented, then a fresh one-entry drain
        mark();
        mem[0] = 16'hABCD; mem[1] = 16'h1234; mem[2] = 16'h00FF;
        log_ptr = 3'd3;
        trigger();
        ack_word(0);
        ack_word(0);
        wait_valid("mid_valid_timeout");
        chk("mid_word2", read_val, 32'h1234);
        puc_rst = 1'b1;
        #1;
        chk("mid_rst_outputs", {dbg_state, word_valid, busy, mem_rd_en, log_clr}, 32'd0);
        tick(2);
        puc_rst = 1'b0;
        tick(3);
        chk("mid_no_clr", clr_cnt - clr_base, 32'd0);

        mark();
        log_ptr = 3'd1;
        exp_q = '{16'h0001, 16'hABCD};
        acfa_nmi = 1'b1;
        tick(1);
        acfa_nmi = 1'b0;
        chk("lat_hdr_pending", {word_valid, busy, dbg_state}, {28'd0, 1'b0, 1'b1, 3'd1});
        tick(1);
        chk("lat_hdr_valid", {word_valid, read_val}, 32'h10001);
        word_ack = 1'b1;
        tick(1);
        word_ack = 1'b0;
        chk("lat_ack_m", {word_valid, mem_rd_en, dbg_state}, {29'd0, 3'd2});
        tick(1);
        chk("lat_ack_m1", {word_valid, mem_rd_en, 6'(mem_addr)}, 32'b0_1_000000);
        tick(1);
        chk("lat_ack_m2", {word_valid, mem_rd_en}, 32'd0);
        tick(1);
        chk("lat_ack_m3", {word_valid, read_val}, 32'h1ABCD);
        ack_word(1);
        chk("fresh_clr_early", log_clr, 32'd0);
        tick(1);
        chk("fresh_clr_pulse", {log_clr, busy}, 32'b10);
        tick(2);
        sb_check("fresh");
        rd_check("fresh", 1);
        chk("fresh_clr_count", clr_cnt - clr_base, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
